card_reader: RTL and testbench

- Upstream input-conditioning stage for `metro_work`, clocked by the divided slow clock `clk_lw`.
- Synchronises and debounces the raw card-presence switch and samples the 3-bit balance switches only once they have held stable.
- Presents a clean `card_inserted` level plus a frozen `balance` value, so `metro_work` never sees bounce or mid-insertion balance changes.
- Flags unreadable cards on `read_err`.

---
 rtl/metro_pkg.sv | 19 +
 rtl/metro_sync2.sv | 25 ++
 rtl/card_reader.sv | 163 ++++++++++++++++
 tb/tb_card_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/metro_pkg.sv
// Shared types and constants for the metro card-reader front end.
// Contents: card_state_t FSM encoding, balance width, default debounce/read counts.
// Imported by card_reader and any consumer that needs the balance width.
package metro_pkg;

  localparam int BAL_W           = 3;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_READ_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEB_IN  = 3'd1,
    SAMPLE  = 3'd2,
    HOLD    = 3'd3,
    DEB_OUT = 3'd4,
    REJECT  = 3'd5
  } card_state_t;

endpackage

// File: rtl/metro_sync2.sv
// Two-flop synchroniser, parameterised width, for asynchronous switch inputs.
// Latency: 2 clk edges from d to q; no backpressure (free-running).
// Ports: clk, rst_n (async active-low, clears both stages to 0), d (async in), q (synchronised out).
module metro_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/card_reader.sv
// Card reader input conditioning: debounces card presence and captures a stable balance.
// Latency: accept 2+DEB_CYCLES+READ_CYCLES edges after first sample high; release 2+DEB_CYCLES edges.
// Backpressure: none; outputs are levels held until the card is removed.
// Ports: clk, reset (async active-low), card_raw, bal_raw -> card_inserted, balance, read_err.
// Optional macro CARD_READER_PARITY_EN adds bal_par_raw and an odd-parity check during sampling.
module card_reader
  import metro_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int READ_CYCLES = DEF_READ_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_raw,
  input  logic [BAL_W-1:0] bal_raw,
`ifdef CARD_READER_PARITY_EN
  input  logic             bal_par_raw,
`endif
  output logic             card_inserted,
  output logic [BAL_W-1:0] balance,
  output logic             read_err
);

  localparam int CNT_MAX = (DEB_CYCLES > READ_CYCLES) ? DEB_CYCLES : READ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);

  logic             card_s;
  logic [BAL_W-1:0] bal_s;
  logic             par_ok;

  card_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [BAL_W-1:0] bal_q;

  metro_sync2 #(.W(1)) u_sync_card (
    .clk   (clk),
    .rst_n (reset),
    .d     (card_raw),
    .q     (card_s)
  );

  metro_sync2 #(.W(BAL_W)) u_sync_bal (
    .clk   (clk),
    .rst_n (reset),
    .d     (bal_raw),
    .q     (bal_s)
  );

`ifdef CARD_READER_PARITY_EN
  logic bal_par_s;

  metro_sync2 #(.W(1)) u_sync_par (
    .clk   (clk),
    .rst_n (reset),
    .d     (bal_par_raw),
    .q     (bal_par_s)
  );

  // Balance bits plus parity bit must carry an odd number of ones.
  assign par_ok = ^{bal_s, bal_par_s};
`else
  assign par_ok = 1'b1;
`endif

  // Every transition clears cnt, so it never needs to count past CNT_MAX-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bal_q         <= '0;
      card_inserted <= 1'b0;
      balance       <= '0;
      read_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (card_s) begin
            state <= DEB_IN;
            cnt   <= '0;
          end
        end

        DEB_IN: begin
          if (!card_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= SAMPLE;
            bal_q <= bal_s;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // bal_q is the candidate; it must be re-observed unchanged for READ_CYCLES.
        SAMPLE: begin
          if (!card_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if ((bal_s != bal_q) || !par_ok) begin
            state    <= REJECT;
            cnt      <= '0;
            read_err <= 1'b1;
          end else if (cnt == READ_LAST) begin
            state         <= HOLD;
            cnt           <= '0;
            balance       <= bal_q;
            card_inserted <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Balance is frozen here; bal_s is deliberately ignored.
        HOLD: begin
          if (!card_s) begin
            state <= DEB_OUT;
            cnt   <= '0;
          end
        end

        DEB_OUT: begin
          if (card_s) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            card_inserted <= 1'b0;
            balance       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Only a continuously removed card clears the error.
        REJECT: begin
          if (card_s) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            read_err <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          cnt           <= '0;
          card_inserted <= 1'b0;
          balance       <= '0;
          read_err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_reader.sv
// Self-checking bench for card_reader with default DEB_CYCLES=4, READ_CYCLES=2.
// Expected outputs are pushed to a queue as each cycle is driven and popped after the edge.
// Parity scenario is compiled in only when CARD_READER_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_card_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       card_raw;
  logic [2:0] bal_raw;
`ifdef CARD_READER_PARITY_EN
  logic       bal_par_raw;
`endif
  logic       card_inserted;
  logic [2:0] balance;
  logic       read_err;

  typedef struct packed {
    logic       ci;
    logic [2:0] bal;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  card_reader dut (
    .clk           (clk),
    .reset         (reset),
    .card_raw      (card_raw),
    .bal_raw       (bal_raw),
`ifdef CARD_READER_PARITY_EN
    .bal_par_raw   (bal_par_raw),
`endif
    .card_inserted (card_inserted),
    .balance       (balance),
    .read_err      (read_err)
  );

  // Advance one rising edge and land 2ns after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    exp_t e, g;
    reset    = 1'b0;
    card_raw = 1'b0;
    bal_raw  = 3'd5;
`ifdef CARD_READER_PARITY_EN
    bal_par_raw = 1'b1;
`endif
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) reset = 1'b1;
      exp_q.push_back('{ci: 1'b0, bal: 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

  // Card rises once and stays; acceptance 8 edges after the first sampling edge.
  task automatic test_clean_insert();
    exp_t e, g;
    bal_raw = 3'd5;
    for (int k = 1; k <= 12; k++) begin
      card_raw = 1'b1;
      exp_q.push_back('{ci: (k >= 9), bal: (k >= 9) ? 3'd5 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL clean_insert k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

  // One-cycle dropout plus balance change must not disturb HOLD; then a real removal.
  task automatic test_removal_glitch();
    exp_t e, g;
    bal_raw = 3'd2;
    for (int k = 1; k <= 10; k++) begin
      card_raw = (k == 1) ? 1'b0 : 1'b1;
      exp_q.push_back('{ci: 1'b1, bal: 3'd5, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL glitch_hold k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
    for (int k = 1; k <= 9; k++) begin
      card_raw = 1'b0;
      exp_q.push_back('{ci: (k < 7), bal: (k < 7) ? 3'd5 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL removal k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

  // card_raw 1,0,1,0 then held high from k=5; acceptance at k=5+8.
  task automatic test_bounce();
    exp_t e, g;
    bal_raw = 3'd5;
    for (int k = 1; k <= 15; k++) begin
      card_raw = (k >= 5) ? 1'b1 : ((k % 2) == 1);
      exp_q.push_back('{ci: (k >= 13), bal: (k >= 13) ? 3'd5 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL bounce k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

  // Asynchronous reset mid-cycle clears outputs at once; held card is re-accepted.
  task automatic test_reset_mid_hold();
    exp_t e, g;
    #3;
    reset = 1'b0;
    #1;
    e = '{ci: 1'b0, bal: 3'd0, err: 1'b0};
    g = {card_inserted, balance, read_err};
    vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL async_reset got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
               g.ci, g.bal, g.err, e.ci, e.bal, e.err);
    end
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      card_raw = 1'b1;
      exp_q.push_back('{ci: (k >= 9), bal: (k >= 9) ? 3'd5 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reaccept k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

  // Balance 3 captured entering SAMPLE, then 6 arrives on the first SAMPLE check.
  task automatic test_unstable_read();
    exp_t e, g;
    for (int k = 1; k <= 9; k++) begin
      card_raw = 1'b0;
      bal_raw  = 3'd3;
      exp_q.push_back('{ci: (k < 7), bal: (k < 7) ? 3'd5 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL pre_remove k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
    for (int k = 1; k <= 18; k++) begin
      card_raw = (k <= 10);
      bal_raw  = (k >= 6) ? 3'd6 : 3'd3;
      exp_q.push_back('{ci: 1'b0, bal: 3'd0, err: (k >= 8) && (k < 16)});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL unstable_read k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask

`ifdef CARD_READER_PARITY_EN
  // 3'b011 with parity 0 is even -> reject; with parity 1 -> accepted as 3.
  task automatic test_parity();
    exp_t e, g;
    for (int k = 1; k <= 18; k++) begin
      card_raw    = (k <= 10);
      bal_raw     = 3'b011;
      bal_par_raw = 1'b0;
      exp_q.push_back('{ci: 1'b0, bal: 3'd0, err: (k >= 8) && (k < 16)});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL parity_bad k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
    bal_par_raw = 1'b1;
    tick();
    tick();
    for (int k = 1; k <= 11; k++) begin
      card_raw = 1'b1;
      exp_q.push_back('{ci: (k >= 9), bal: (k >= 9) ? 3'd3 : 3'd0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      g = {card_inserted, balance, read_err};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL parity_good k=%0d got ci=%b bal=%0d err=%b want ci=%b bal=%0d err=%b",
                 k, g.ci, g.bal, g.err, e.ci, e.bal, e.err);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_insert();
    test_removal_glitch();
    test_bounce();
    test_reset_mid_hold();
    test_unstable_read();
`ifdef CARD_READER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
